// File: rtl/mbconv_ofm_buffer_if.sv
// Purpose: bundle of configuration, pixel-input, read-port and status signals
//          between the MBConv PE cluster / next-layer reader and the OFM buffer.
// Ports (slave = buffer side):
//   cfg_start, cfg_ofm_w, cfg_ofm_h, cfg_pad, cfg_relu : frame configuration
//   in_valid, in_data / in_ready                       : pixel write handshake
//   rd_en, rd_addr / rd_data, rd_valid                 : lane-sliced read port
//   busy, frame_done, overflow, cfg_err                : status
interface mbconv_ofm_buffer_if #(
    parameter int unsigned NUM_PE = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_W   = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LANE_W = 2
);
    logic                       cfg_start;
    logic [7:0]                 cfg_ofm_w;
    logic [7:0]                 cfg_ofm_h;
    logic [1:0]                 cfg_pad;
    logic                       cfg_relu;
    logic                       in_valid;
    logic [NUM_PE*DATA_W-1:0]   in_data;
    logic                       in_ready;
    logic                       rd_en;
    logic [ADDR_W+LANE_W-1:0]   rd_addr;
    logic [RD_W-1:0]            rd_data;
    logic                       rd_valid;
    logic                       busy;
    logic                       frame_done;
    logic                       overflow;
    logic                       cfg_err;

    modport slave (
        input  cfg_start, cfg_ofm_w, cfg_ofm_h, cfg_pad, cfg_relu,
        input  in_valid, in_data, rd_en, rd_addr,
        output in_ready, rd_data, rd_valid, busy, frame_done, overflow, cfg_err
    );

    modport master (
        output cfg_start, cfg_ofm_w, cfg_ofm_h, cfg_pad, cfg_relu,
        output in_valid, in_data, rd_en, rd_addr,
        input  in_ready, rd_data, rd_valid, busy, frame_done, overflow, cfg_err
    );
endinterface

// File: rtl/mbconv_ofm_buffer.sv
// Purpose: OFM write-back buffer. Captures NUM_PE-channel pixels from the PE
//          cluster, optionally applies ReLU, and stores them in raster order
//          inside a zero-padded frame; the next layer reads it back through a
//          narrower lane-sliced port.
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : mbconv_ofm_buffer_if.slave (config, pixel handshake, read port, status)
module mbconv_ofm_buffer #(
    parameter int unsigned NUM_PE = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned RD_W   = 32,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned LANE_W = ($clog2(NUM_PE*DATA_W/RD_W) > 0) ?
                                    $clog2(NUM_PE*DATA_W/RD_W) : 1
) (
    input  logic               clk,
    input  logic               reset,
    mbconv_ofm_buffer_if.slave bus
);

    localparam int unsigned WORD_W = NUM_PE * DATA_W;
    localparam int unsigned CNT_W  = 17;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_FILL  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [WORD_W-1:0]  r_mem [DEPTH];

    logic [7:0]         r_w, r_h;
    logic [1:0]         r_pad;
    logic               r_relu;
    logic [CNT_W-1:0]   r_n;
    logic [CNT_W-1:0]   r_clr_cnt, w_clr_cnt_nxt;
    logic [CNT_W-1:0]   r_wa, w_wa_nxt;
    logic [7:0]         r_col, w_col_nxt;
    logic [7:0]         r_row, w_row_nxt;

    logic               r_in_ready, w_in_ready_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_frame_done, w_frame_done_nxt;
    logic               r_overflow, w_overflow_nxt;
    logic               r_cfg_err, w_cfg_err_nxt;
    logic               r_rd_valid;
    logic [RD_W-1:0]    r_rd_data;

    logic [8:0]         w_wp, w_hp;
    logic [CNT_W-1:0]   w_n, w_first_wa;
    logic               w_cfg_bad;
    logic               w_cfg_latch;
    logic               w_accept;
    logic               w_we;
    logic [ADDR_W-1:0]  w_waddr;
    logic [WORD_W-1:0]  w_wdata;
    logic [WORD_W-1:0]  w_relu_data;
    logic [ADDR_W-1:0]  w_rd_entry;
    logic [LANE_W-1:0]  w_rd_lane;
    logic [RD_W-1:0]    w_rd_slice;

    // Padded geometry of the frame being offered on cfg_*
    assign w_wp       = 9'(bus.cfg_ofm_w) + 9'({bus.cfg_pad, 1'b0});
    assign w_hp       = 9'(bus.cfg_ofm_h) + 9'({bus.cfg_pad, 1'b0});
    assign w_n        = CNT_W'(w_wp) * CNT_W'(w_hp);
    assign w_first_wa = CNT_W'(bus.cfg_pad) * CNT_W'(w_wp) + CNT_W'(bus.cfg_pad);
    assign w_cfg_bad  = (32'(w_n) > DEPTH) || (bus.cfg_ofm_w == 8'd0) ||
                        (bus.cfg_ofm_h == 8'd0);
    assign w_accept   = bus.in_valid & r_in_ready;

    // ReLU: zero every lane whose sign bit is set
    always_comb begin
        w_relu_data = bus.in_data;
        for (int k = 0; k < int'(NUM_PE); k++) begin
            if (r_relu && bus.in_data[k*DATA_W + DATA_W - 1]) begin
                w_relu_data[k*DATA_W +: DATA_W] = '0;
            end
        end
    end

    // Next-state, counters and write port
    always_comb begin
        w_state_nxt      = r_state;
        w_clr_cnt_nxt    = r_clr_cnt;
        w_col_nxt        = r_col;
        w_row_nxt        = r_row;
        w_wa_nxt         = r_wa;
        w_cfg_err_nxt    = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_overflow_nxt   = r_overflow | (bus.in_valid & r_busy & ~r_in_ready);
        w_cfg_latch      = 1'b0;
        w_we             = 1'b0;
        w_waddr          = ADDR_W'(r_wa);
        w_wdata          = w_relu_data;

        case (r_state)
            S_IDLE: begin
                if (bus.cfg_start) begin
                    if (w_cfg_bad) begin
                        w_cfg_err_nxt = 1'b1;
                    end else begin
                        w_cfg_latch    = 1'b1;
                        w_overflow_nxt = 1'b0;
                        w_clr_cnt_nxt  = '0;
                        w_col_nxt      = '0;
                        w_row_nxt      = '0;
                        w_wa_nxt       = w_first_wa;
                        w_state_nxt    = (bus.cfg_pad != 2'd0) ? S_CLEAR : S_FILL;
                    end
                end
            end
            S_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = ADDR_W'(r_clr_cnt);
                w_wdata = '0;
                if (r_clr_cnt == r_n - CNT_W'(1)) begin
                    w_state_nxt = S_FILL;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + CNT_W'(1);
                end
            end
            S_FILL: begin
                if (w_accept) begin
                    w_we = 1'b1;
                    if (r_col == r_w - 8'd1) begin
                        // Skip right border of this row and left border of the next
                        w_col_nxt = '0;
                        w_row_nxt = r_row + 8'd1;
                        w_wa_nxt  = r_wa + CNT_W'({r_pad, 1'b1});
                        if (r_row == r_h - 8'd1) begin
                            w_state_nxt      = S_IDLE;
                            w_frame_done_nxt = 1'b1;
                        end
                    end else begin
                        w_col_nxt = r_col + 8'd1;
                        w_wa_nxt  = r_wa + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_in_ready_nxt = (w_state_nxt == S_FILL);
        w_busy_nxt     = (w_state_nxt != S_IDLE);
    end

    // State, counters, config and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_clr_cnt    <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_wa         <= '0;
            r_w          <= '0;
            r_h          <= '0;
            r_pad        <= '0;
            r_relu       <= 1'b0;
            r_n          <= '0;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_clr_cnt    <= w_clr_cnt_nxt;
            r_col        <= w_col_nxt;
            r_row        <= w_row_nxt;
            r_wa         <= w_wa_nxt;
            r_in_ready   <= w_in_ready_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_overflow   <= w_overflow_nxt;
            r_cfg_err    <= w_cfg_err_nxt;
            if (w_cfg_latch) begin
                r_w    <= bus.cfg_ofm_w;
                r_h    <= bus.cfg_ofm_h;
                r_pad  <= bus.cfg_pad;
                r_relu <= bus.cfg_relu;
                r_n    <= w_n;
            end
        end
    end

    // Pixel storage; contents survive reset
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Read slice: entry select then lane shift; out-of-range entries read zero
    assign w_rd_entry = bus.rd_addr[ADDR_W+LANE_W-1:LANE_W];
    assign w_rd_lane  = bus.rd_addr[LANE_W-1:0];

    always_comb begin
        w_rd_slice = '0;
        if (32'(w_rd_entry) < DEPTH) begin
            w_rd_slice = RD_W'(r_mem[w_rd_entry] >> (32'(w_rd_lane) * RD_W));
        end
    end

    // Registered read port (read-first against a same-cycle write)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                r_rd_data <= w_rd_slice;
            end
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;
    assign bus.overflow   = r_overflow;
    assign bus.cfg_err    = r_cfg_err;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_data    = r_rd_data;

endmodule

// File: tb/tb_mbconv_ofm_buffer.sv
// Self-checking bench for mbconv_ofm_buffer: table-driven frame vectors,
// hand-written corner sequences and randomized frames against a padded-frame
// reference model.
module tb_mbconv_ofm_buffer;

    localparam int unsigned NUM_PE = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned RD_W   = 32;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned LANE_W = 2;
    localparam int unsigned NLANE  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mbconv_ofm_buffer_if #(
        .NUM_PE(NUM_PE), .DATA_W(DATA_W), .RD_W(RD_W), .ADDR_W(ADDR_W), .LANE_W(LANE_W)
    ) bus ();

    mbconv_ofm_buffer #(
        .NUM_PE(NUM_PE), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_W(RD_W),
        .ADDR_W(ADDR_W), .LANE_W(LANE_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          w;
        int          h;
        int          p;
        bit          relu;
        int          gap;      // 0 back-to-back, 1 alternate, 2 random
        bit          seq;      // pixel i lanes = i+1, else random
        bit          exp_err;
        int          exp_lat;  // cycles from cfg_start to in_ready
        int          hc_e0;
        logic [31:0] hc_v0;
        int          hc_e1;
        logic [31:0] hc_v1;
    } vec_t;

    int total = 0;
    int bad   = 0;
    bit ovf_exp = 1'b0;

    logic [127:0] exp_mem [DEPTH];
    bit           known   [DEPTH];
    logic [127:0] pix_q   [$];
    vec_t         vecs    [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] relu_f(input logic [127:0] d, input bit en);
        logic [127:0] o;
        logic [7:0]   b;
        o = d;
        for (int k = 0; k < 16; k++) begin
            b = d[k*8 +: 8];
            if (en && $signed(b) < 0) o[k*8 +: 8] = 8'h00;
        end
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic gen_pixels(input int n, input bit seq);
        logic [7:0] b;
        pix_q.delete();
        for (int i = 0; i < n; i++) begin
            b = 8'(i + 1);
            if (seq) pix_q.push_back({16{b}});
            else     pix_q.push_back(rnd128());
        end
    endtask

    // Reference: pixel (r,c) lands at (r+P)*Wp + (c+P); border zeroed when P>0
    task automatic model_frame(input int w, input int h, input int p, input bit relu);
        int wp, n, idx;
        wp = w + 2*p;
        n  = wp * (h + 2*p);
        if (p > 0) begin
            for (int e = 0; e < n; e++) begin
                exp_mem[e] = '0;
                known[e]   = 1'b1;
            end
        end
        for (int i = 0; i < w*h; i++) begin
            idx = (i / w + p) * wp + (i % w) + p;
            exp_mem[idx] = relu_f(pix_q[i], relu);
            known[idx]   = 1'b1;
        end
    endtask

    task automatic rd_once(input logic [11:0] a, output logic [31:0] d);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        tick();
        chk("rd_valid", 128'(bus.rd_valid), 128'(1));
        d = bus.rd_data;
        bus.rd_en = 1'b0;
    endtask

    task automatic check_mem(input int n);
        logic [31:0] d;
        for (int e = 0; e < n; e++) begin
            if (known[e]) begin
                for (int l = 0; l < int'(NLANE); l++) begin
                    rd_once(12'(e*4 + l), d);
                    chk($sformatf("mem[%0d].%0d", e, l), 128'(d), 128'(exp_mem[e][l*32 +: 32]));
                end
            end
        end
    endtask

    task automatic start_cfg(input int w, input int h, input int p, input bit relu);
        bus.cfg_ofm_w = 8'(w);
        bus.cfg_ofm_h = 8'(h);
        bus.cfg_pad   = 2'(p);
        bus.cfg_relu  = relu;
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
    endtask

    // Feeds pixels from pix_q while in FILL; stops after n_send beats
    task automatic run_fill(input int n_send, input int n_total, input int gap, input bit poke_start);
        int sent = 0;
        int cyc  = 0;
        bit alt  = 1'b0;
        bit v;
        bit poked;
        while (sent < n_send && cyc < 4*n_total + 20) begin
            v = (gap == 0) ? 1'b1 : (gap == 1) ? alt : ($urandom_range(0, 3) != 0);
            alt = ~alt;
            chk("in_ready_fill", 128'(bus.in_ready), 128'(1));
            bus.in_valid = v;
            bus.in_data  = v ? pix_q[sent] : rnd128();
            poked = poke_start && (cyc == 1);
            if (poked) begin
                bus.cfg_ofm_w = 8'd0;
                bus.cfg_start = 1'b1;
            end
            tick();
            cyc++;
            if (v) sent++;
            bus.in_valid  = 1'b0;
            bus.cfg_start = 1'b0;
            if (poked) chk("cfg_start_busy_err", 128'(bus.cfg_err), 128'(0));
            if (v && sent == n_total) begin
                chk("frame_done", 128'(bus.frame_done), 128'(1));
                chk("busy_end", 128'(bus.busy), 128'(0));
                chk("in_ready_end", 128'(bus.in_ready), 128'(0));
            end else begin
                chk("frame_done_early", 128'(bus.frame_done), 128'(0));
                chk("busy_fill", 128'(bus.busy), 128'(1));
            end
        end
        chk("fill_beats", 128'(sent), 128'(n_send));
    endtask

    // Full frame: config, clear phase (optionally poked), fill, memory compare
    task automatic do_frame(input vec_t v, input int poke_clear, input bit poke_start);
        int lat;
        int n;
        logic [31:0] d;
        n = (v.w + 2*v.p) * (v.h + 2*v.p);
        start_cfg(v.w, v.h, v.p, v.relu);
        chk("cfg_err", 128'(bus.cfg_err), 128'(v.exp_err));
        chk("busy_start", 128'(bus.busy), 128'(!v.exp_err));
        if (!v.exp_err) ovf_exp = 1'b0;
        chk("overflow_start", 128'(bus.overflow), 128'(ovf_exp));
        if (v.exp_err) begin
            tick();
            chk("cfg_err_pulse", 128'(bus.cfg_err), 128'(0));
            chk("busy_rejected", 128'(bus.busy), 128'(0));
            chk("in_ready_rejected", 128'(bus.in_ready), 128'(0));
            return;
        end
        lat = 1;
        while (!bus.in_ready && lat < v.exp_lat + 8) begin
            bus.in_valid = (poke_clear == 2) ? 1'b1 :
                           (poke_clear == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.in_data  = rnd128();
            if (bus.in_valid) ovf_exp = 1'b1;
            tick();
            lat++;
        end
        bus.in_valid = 1'b0;
        chk("ready_latency", 128'(lat), 128'(v.exp_lat));
        chk("overflow_clear", 128'(bus.overflow), 128'(ovf_exp));
        gen_pixels(v.w * v.h, v.seq);
        run_fill(v.w * v.h, v.w * v.h, v.gap, poke_start);
        model_frame(v.w, v.h, v.p, v.relu);
        chk("overflow_end", 128'(bus.overflow), 128'(ovf_exp));
        check_mem(n);
        if (v.hc_e0 >= 0) begin
            rd_once(12'(v.hc_e0 * 4), d);
            chk("hand_e0", 128'(d), 128'(v.hc_v0));
        end
        if (v.hc_e1 >= 0) begin
            rd_once(12'(v.hc_e1 * 4), d);
            chk("hand_e1", 128'(d), 128'(v.hc_v1));
        end
    endtask

    initial begin
        logic [127:0] d0, d1;
        logic [31:0]  d;
        vec_t         rv;
        int           n;

        for (int e = 0; e < int'(DEPTH); e++) known[e] = 1'b0;
        reset         = 1'b1;
        bus.cfg_start = 1'b0;
        bus.cfg_ofm_w = '0;
        bus.cfg_ofm_h = '0;
        bus.cfg_pad   = '0;
        bus.cfg_relu  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;
        repeat (3) tick();
        chk("rst_in_ready",   128'(bus.in_ready),   128'(0));
        chk("rst_busy",       128'(bus.busy),       128'(0));
        chk("rst_frame_done", 128'(bus.frame_done), 128'(0));
        chk("rst_overflow",   128'(bus.overflow),   128'(0));
        chk("rst_cfg_err",    128'(bus.cfg_err),    128'(0));
        chk("rst_rd_valid",   128'(bus.rd_valid),   128'(0));
        chk("rst_rd_data",    128'(bus.rd_data),    128'(0));
        reset = 1'b0;
        tick();

        //          w   h  p relu gap seq err lat   hand checks
        vecs[0] = '{4,  4, 1, 0,  0,  1,  0,  37,   7, 32'h01010101, 28, 32'h10101010};
        vecs[1] = '{3,  2, 0, 0,  1,  1,  0,  1,    0, 32'h01010101,  5, 32'h06060606};
        vecs[2] = '{31, 31, 1, 0, 0,  0,  1,  0,   -1, 32'h0,        -1, 32'h0};
        vecs[3] = '{2,  3, 2, 1,  2,  0,  0,  43,  -1, 32'h0,        -1, 32'h0};
        vecs[4] = '{32, 32, 0, 0, 0,  0,  0,  1,   -1, 32'h0,        -1, 32'h0};
        vecs[5] = '{0,  5, 0, 0,  0,  0,  1,  0,   -1, 32'h0,        -1, 32'h0};
        vecs[6] = '{30, 30, 1, 1, 2,  0,  0,  1025,-1, 32'h0,        -1, 32'h0};
        vecs[7] = '{5,  0, 0, 0,  0,  0,  1,  0,   -1, 32'h0,        -1, 32'h0};
        vecs[8] = '{1,  1, 3, 0,  0,  1,  0,  50,  24, 32'h01010101,  0, 32'h0};
        vecs[9] = '{32, 33, 0, 0, 0,  0,  1,  0,   -1, 32'h0,        -1, 32'h0};
        for (int i = 0; i < 10; i++) do_frame(vecs[i], 0, 1'b0);

        // Overflow during clear, survives a rejected config, cleared by the next accepted one
        do_frame('{8, 8, 2, 0, 0, 0, 0, 145, -1, 32'h0, -1, 32'h0}, 2, 1'b0);
        chk("overflow_sticky", 128'(bus.overflow), 128'(1));
        do_frame(vecs[2], 0, 1'b0);
        do_frame('{1, 1, 0, 0, 0, 0, 0, 1, -1, 32'h0, -1, 32'h0}, 0, 1'b0);
        chk("overflow_cleared", 128'(bus.overflow), 128'(0));

        // ReLU, lane slicing, read-first and read hold
        d0 = 128'h0F0E0D0C0B0A0908_0706050403020100;
        d1 = 128'h40C041C142C243C3_3322117F80068505;
        start_cfg(1, 1, 0, 1'b0);
        chk("relu_a_ready", 128'(bus.in_ready), 128'(1));
        bus.in_valid = 1'b1;
        bus.in_data  = d0;
        tick();
        bus.in_valid = 1'b0;
        chk("relu_a_done", 128'(bus.frame_done), 128'(1));
        start_cfg(1, 1, 0, 1'b1);
        chk("relu_b_ready", 128'(bus.in_ready), 128'(1));
        bus.in_valid = 1'b1;
        bus.in_data  = d1;
        bus.rd_en    = 1'b1;
        bus.rd_addr  = 12'd1;
        tick();
        bus.in_valid = 1'b0;
        bus.rd_en    = 1'b0;
        chk("read_first_old", 128'(bus.rd_data), 128'(32'h07060504));
        chk("relu_b_done", 128'(bus.frame_done), 128'(1));
        rd_once(12'd1, d);
        chk("relu_lane1", 128'(d), 128'(32'h3322117F));
        rd_once(12'd0, d);
        chk("relu_lane0", 128'(d), 128'(32'h00060005));
        tick();
        chk("rd_hold_valid", 128'(bus.rd_valid), 128'(0));
        chk("rd_hold_data", 128'(bus.rd_data), 128'(32'h00060005));
        exp_mem[0] = relu_f(d1, 1'b1);
        known[0]   = 1'b1;
        ovf_exp    = 1'b0;

        // Reset after 5 of 16 beats, then a full frame
        start_cfg(4, 4, 0, 1'b0);
        chk("rst_mid_ready", 128'(bus.in_ready), 128'(1));
        gen_pixels(16, 1'b0);
        run_fill(5, 16, 0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rmid_in_ready",   128'(bus.in_ready),   128'(0));
        chk("rmid_busy",       128'(bus.busy),       128'(0));
        chk("rmid_frame_done", 128'(bus.frame_done), 128'(0));
        chk("rmid_overflow",   128'(bus.overflow),   128'(0));
        chk("rmid_cfg_err",    128'(bus.cfg_err),    128'(0));
        chk("rmid_rd_valid",   128'(bus.rd_valid),   128'(0));
        chk("rmid_rd_data",    128'(bus.rd_data),    128'(0));
        for (int e = 0; e < 16; e++) known[e] = 1'b0;
        do_frame('{4, 4, 0, 0, 0, 1, 0, 1, 15, 32'h10101010, -1, 32'h0}, 0, 1'b0);

        // Randomized frames against the model
        for (int it = 0; it < 10; it++) begin
            rv.w    = $urandom_range(1, 8);
            rv.h    = $urandom_range(1, 8);
            rv.p    = $urandom_range(0, 3);
            rv.relu = 1'($urandom_range(0, 1));
            rv.gap  = $urandom_range(0, 2);
            rv.seq  = 1'b0;
            n       = (rv.w + 2*rv.p) * (rv.h + 2*rv.p);
            rv.exp_err = (n > int'(DEPTH));
            rv.exp_lat = (rv.p > 0) ? n + 1 : 1;
            rv.hc_e0 = -1; rv.hc_v0 = '0;
            rv.hc_e1 = -1; rv.hc_v1 = '0;
            do_frame(rv, 1, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
